// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage and the units that consume
// its IF/ID outputs (hazard detection, decode):
//   - default reset PC and bubble instruction
//   - RV32 instruction field bit positions
//   - 8-bit packed {funct3, opcode[6:2]} encodings used by the hazard unit
//   - IF/ID pipeline register payload struct
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  // Instruction field bit positions
  localparam int OPC_LSB = 2;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // Packed {funct3, opcode[6:2]} encodings seen by the hazard unit
  localparam logic [7:0] PK_BEQ  = 8'b000_11000;
  localparam logic [7:0] PK_BNE  = 8'b001_11000;
  localparam logic [7:0] PK_BLT  = 8'b100_11000;
  localparam logic [7:0] PK_BGE  = 8'b101_11000;
  localparam logic [7:0] PK_BLTU = 8'b110_11000;
  localparam logic [7:0] PK_BGEU = 8'b111_11000;
  localparam logic [7:0] PK_JALR = 8'b000_11001;
  // jal has no funct3; only the low 5 bits identify it
  localparam logic [4:0] PK_JAL_LOW5 = 5'b11011;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Build the packed opcode field from its two instruction slices
  function automatic logic [7:0] pack_opcode(input logic [2:0] funct3,
                                             input logic [4:0] opc5);
    return {funct3, opc5};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Update priority on each rising edge:
//   rst > flush (bubble, PC taken from IF) > hold (keep) > load.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : 1 = load a bubble (NOP, valid=0) tagged with pc_in
//   hold_n       : active-low hold; 0 = keep current contents
//   pc_in        : PC of the instruction currently in IF
//   instr_in     : instruction currently in IF (from instruction memory)
//   if_id_o      : registered IF/ID payload
// -----------------------------------------------------------------------------
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output if_id_t      if_id_o
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Next-state selection: flush beats hold, hold beats a normal load
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.pc    = pc_in;
      if_id_d.pc4   = pc_in + 32'd4;
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!hold_n) begin
      if_id_d = if_id_q;
    end else begin
      if_id_d.pc    = pc_in;
      if_id_d.pc4   = pc_in + 32'd4;
      if_id_d.instr = instr_in;
      if_id_d.valid = 1'b1;
    end
  end

  // Register with synchronous reset to a bubble at RESET_PC
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.pc    <= RESET_PC;
      if_id_q.pc4   <= RESET_PC + 32'd4;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: program counter, synchronous instruction-memory
// address, and the IF/ID pipeline register.
// Optional feature macro: FETCH_PERF_EN (performance counters). When it is not
// defined the perf_* ports remain and are tied to zero.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   PCWrite                          : 1 = PC may advance, 0 = PC frozen
//   IF_ID_Hold                       : active-low hold of the IF/ID register
//   IF_ID_Flush                      : 1 = IF/ID loads a bubble
//   redirect_valid/redirect_target   : taken branch/jump resolved in ID
//   imem_addr / imem_rdata           : sync-read instruction memory (1-cycle)
//   IF_ID_PC/PC4/Instr/Valid         : registered IF/ID contents
//   IF_ID_Opcode/Rs/Rt               : fields decoded from IF_ID_Instr
//   perf_fetch/stall/flush_cnt       : performance counters
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Hold,
  input  logic        IF_ID_Flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic [7:0]  IF_ID_Opcode,
  output logic [4:0]  IF_ID_Rs,
  output logic [4:0]  IF_ID_Rt,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  if_id_t      if_id_s;
  logic        unused_target_lsbs;

  // Target is always word aligned; the low bits are dropped
  assign unused_target_lsbs = ^redirect_target[1:0];

  // Next PC: a stall overrides a redirect, so a redirect under stall is lost
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (!PCWrite) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Presenting pc_d makes next cycle's imem_rdata the word at pc_q; a frozen
  // PC simply re-reads the same word.
  assign imem_addr = pc_d;

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (IF_ID_Flush),
    .hold_n   (IF_ID_Hold),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .if_id_o  (if_id_s)
  );

  assign IF_ID_PC     = if_id_s.pc;
  assign IF_ID_PC4    = if_id_s.pc4;
  assign IF_ID_Instr  = if_id_s.instr;
  assign IF_ID_Valid  = if_id_s.valid;
  assign IF_ID_Opcode = pack_opcode(if_id_s.instr[F3_MSB:F3_LSB],
                                    if_id_s.instr[OPC_MSB:OPC_LSB]);
  assign IF_ID_Rs     = if_id_s.instr[RS1_MSB:RS1_LSB];
  assign IF_ID_Rt     = if_id_s.instr[RS2_MSB:RS2_LSB];

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; a flush is never counted as a stall
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (IF_ID_Flush) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!IF_ID_Hold) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Self-checking bench for if_fetch_stage: a directed vector table, hand-written
// wrap and counter sequences, and randomized control traffic compared against a
// behavioural model (instruction in IF = memory word at the IF PC).
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, PCWrite, IF_ID_Hold, IF_ID_Flush, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_rdata;
  logic [31:0] IF_ID_PC, IF_ID_PC4, IF_ID_Instr;
  logic        IF_ID_Valid;
  logic [7:0]  IF_ID_Opcode;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Hold(IF_ID_Hold),
    .IF_ID_Flush(IF_ID_Flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .IF_ID_PC(IF_ID_PC), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid),
    .IF_ID_Opcode(IF_ID_Opcode), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  // Instruction memory contents: word[a] = a, or a scrambled pattern
  logic scramble = 1'b0;
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic s);
    return s ? (a ^ {a[7:0], a[31:8]} ^ 32'h00A5_5A33) : a;
  endfunction

  // Synchronous-read memory: data for last cycle's address
  always @(posedge clk) imem_rdata <= mem_word(imem_addr, scramble);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_id_pc = 32'h0, m_id_instr = 32'h0;
  logic        m_id_valid = 1'b0;
  logic [31:0] m_fc = 32'h0, m_sc = 32'h0, m_flc = 32'h0;

  // One clock cycle: drive controls, check address, clock, update model, check
  task automatic step(input logic r, input logic pw, input logic hn, input logic fl,
                      input logic rv, input logic [31:0] tg, output logic [31:0] addr_seen);
    logic [31:0] exp_addr;
    logic [31:0] e_fc, e_sc, e_flc;
    rst = r; PCWrite = pw; IF_ID_Hold = hn; IF_ID_Flush = fl;
    redirect_valid = rv; redirect_target = tg;
    if (!r && pw && !hn && !fl)
      $display("WARN: PCWrite=1 with IF_ID_Hold=0 drops an instruction (t=%0t)", $time);
    if (r)        exp_addr = RESET_PC_DEF;
    else if (!pw) exp_addr = m_pc;
    else if (rv)  exp_addr = tg & 32'hFFFF_FFFC;
    else          exp_addr = m_pc + 32'd4;
    #1;
    addr_seen = imem_addr;
    chk("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    if (r) begin
      m_id_pc = RESET_PC_DEF; m_id_instr = NOP_INSTR_DEF; m_id_valid = 1'b0;
      m_fc = 32'h0; m_sc = 32'h0; m_flc = 32'h0;
    end else if (fl) begin
      m_id_pc = m_pc; m_id_instr = NOP_INSTR_DEF; m_id_valid = 1'b0; m_flc++;
    end else if (!hn) begin
      m_sc++;
    end else begin
      m_id_pc = m_pc; m_id_instr = mem_word(m_pc, scramble); m_id_valid = 1'b1; m_fc++;
    end
    m_pc = exp_addr;
`ifdef FETCH_PERF_EN
    e_fc = m_fc; e_sc = m_sc; e_flc = m_flc;
`else
    e_fc = 32'h0; e_sc = 32'h0; e_flc = 32'h0;
`endif
    #1;
    chk("IF_ID_PC", IF_ID_PC, m_id_pc);
    chk("IF_ID_PC4", IF_ID_PC4, m_id_pc + 32'd4);
    chk("IF_ID_Instr", IF_ID_Instr, m_id_instr);
    chk("IF_ID_Valid", {31'h0, IF_ID_Valid}, {31'h0, m_id_valid});
    chk("IF_ID_Opcode", {24'h0, IF_ID_Opcode}, {24'h0, m_id_instr[14:12], m_id_instr[6:2]});
    chk("IF_ID_Rs", {27'h0, IF_ID_Rs}, {27'h0, m_id_instr[19:15]});
    chk("IF_ID_Rt", {27'h0, IF_ID_Rt}, {27'h0, m_id_instr[24:20]});
    chk("perf_fetch_cnt", perf_fetch_cnt, e_fc);
    chk("perf_stall_cnt", perf_stall_cnt, e_sc);
    chk("perf_flush_cnt", perf_flush_cnt, e_flc);
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, pw, hn, fl, rv;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_pc, e_instr;
    logic        e_valid;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [31:0] a;
    logic        stall, r, fl, rv;
    logic [31:0] tg;
    logic [31:0] e_fc, e_sc, e_flc;

    // r  pw  hn  fl  rv  target        addr           IF_ID_PC       Instr          Valid
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,   32'h13,  1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,   32'h13,  1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h4,   32'h0,   32'h0,   1'b1};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h8,   32'h4,   32'h4,   1'b1};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'hC,   32'h8,   32'h8,   1'b1};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h10,  32'hC,   32'hC,   1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h10,  32'hC,   32'hC,   1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h10,  32'hC,   32'hC,   1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h10,  32'hC,   32'hC,   1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h14,  32'h10,  32'h10,  1'b1};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1,32'h103,32'h100, 32'h14,  32'h13,  1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h104, 32'h100, 32'h100, 1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h200,32'h104, 32'h100, 32'h100, 1'b1};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h108, 32'h104, 32'h104, 1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  32'h108, 32'h108, 32'h13,  1'b0};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h10C, 32'h108, 32'h108, 1'b1};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h10C, 32'h108, 32'h108, 1'b1};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,   32'h0,   32'h13,  1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  32'h4,   32'h0,   32'h0,   1'b1};

    rst = 1'b1; PCWrite = 1'b1; IF_ID_Hold = 1'b1; IF_ID_Flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    @(negedge clk);

    // Directed table: reset release, stall, redirect, discarded redirect,
    // flush+hold, reset during stall
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].pw, tbl[i].hn, tbl[i].fl, tbl[i].rv, tbl[i].tgt, a);
      chk($sformatf("tbl[%0d].addr", i), a, tbl[i].e_addr);
      chk($sformatf("tbl[%0d].pc", i), IF_ID_PC, tbl[i].e_pc);
      chk($sformatf("tbl[%0d].pc4", i), IF_ID_PC4, tbl[i].e_pc + 32'd4);
      chk($sformatf("tbl[%0d].instr", i), IF_ID_Instr, tbl[i].e_instr);
      chk($sformatf("tbl[%0d].valid", i), {31'h0, IF_ID_Valid}, {31'h0, tbl[i].e_valid});
    end

    // PC wrap: redirect to the last word, then fetch sequentially
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, a);
    chk("wrap.addr0", a, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, a);
    chk("wrap.addr1", a, 32'h0000_0000);
    chk("wrap.pc", IF_ID_PC, 32'hFFFF_FFFC);
    chk("wrap.pc4", IF_ID_PC4, 32'h0000_0000);
    chk("wrap.instr", IF_ID_Instr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, a);
    chk("wrap.pc_after", IF_ID_PC, 32'h0000_0000);
    chk("wrap.valid_after", {31'h0, IF_ID_Valid}, 32'h1);

    // Counters: 10 fetches, 3 stall cycles, 2 flushes after reset
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, a);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, a);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, a);
    for (int i = 0; i < 2; i++)  step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, a);
`ifdef FETCH_PERF_EN
    e_fc = 32'd10; e_sc = 32'd3; e_flc = 32'd2;
`else
    e_fc = 32'd0;  e_sc = 32'd0; e_flc = 32'd0;
`endif
    chk("cnt.fetch", perf_fetch_cnt, e_fc);
    chk("cnt.stall", perf_stall_cnt, e_sc);
    chk("cnt.flush", perf_flush_cnt, e_flc);

    // Randomized controls against the model, scrambled memory contents
    scramble = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, a);
    for (int i = 0; i < 500; i++) begin
      r     = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      fl    = ($urandom_range(0, 6) == 0);
      rv    = ($urandom_range(0, 5) == 0);
      if (rv && !stall && ($urandom_range(0, 3) != 0)) fl = 1'b1;
      tg    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r, !stall, !stall, fl, rv, tg, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
